// File: rtl/exe_stage_mc.sv
// MIPS execute stage: single-cycle ALU, iterative MULTU/DIVU writing HI/LO,
// and an EX/MEM output register.
module exe_stage_mc #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int SHAMT_W    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      rd1,
  input  logic [WIDTH-1:0]      rd2,
  input  logic [WIDTH-1:0]      imm,
  input  logic                  alu_src,
  input  logic [SHAMT_W-1:0]    shamt,
  input  logic [5:0]            alu_op,
  input  logic [REG_ADDR_W-1:0] wr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      alu_result,
  output logic                  zero,
  output logic [WIDTH-1:0]      rd2_out,
  output logic [REG_ADDR_W-1:0] wr_out,
  output logic [WIDTH-1:0]      hi,
  output logic [WIDTH-1:0]      lo,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  // Handshake: a transfer occurs on a rising edge where valid && ready are both
  // high; a producer holding valid keeps its payload stable until it transfers.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b, rd2_hold;
  logic [WIDTH-1:0] op_b, alu_y, iter_hi, iter_lo;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             accept, is_multi, out_free, iter_done, mc_load;

  assign op_b      = alu_src ? imm : rd2;
  assign is_multi  = (alu_op == 6'd16) || (alu_op == 6'd17);
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = (state == S_IDLE) && out_free;
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_comb begin
    alu_y = '0;
    case (alu_op)
      6'd0:  alu_y = rd1 + op_b;
      6'd1:  alu_y = rd1 - op_b;
      6'd2:  alu_y = rd1 & op_b;
      6'd3:  alu_y = rd1 | op_b;
      6'd4:  alu_y = rd1 ^ op_b;
      6'd5:  alu_y = ~(rd1 | op_b);
      6'd6:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(rd1) < $signed(op_b))};
      6'd7:  alu_y = {{(WIDTH-1){1'b0}}, (rd1 < op_b)};
      6'd8:  alu_y = op_b << shamt;
      6'd9:  alu_y = op_b >> shamt;
      6'd10: alu_y = $unsigned($signed(op_b) >>> shamt);
      6'd11: alu_y = hi;
      6'd12: alu_y = lo;
      default: alu_y = '0;
    endcase
  end

  // acc_hi is the partial product / remainder, acc_lo shifts out multiplier
  // bits or shifts in quotient bits; both land directly in HI/LO.
  assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_b : {WIDTH{1'b0}})};
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_b};

  always_comb begin
    iter_hi = acc_hi;
    iter_lo = acc_lo;
    if (state == S_MUL) begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      if (!div_diff[WIDTH]) begin
        iter_hi = div_diff[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign iter_done = ((state == S_MUL) || (state == S_DIV)) && (cnt == '0);
  assign mc_load   = (iter_done || (state == S_DONE)) && out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd_b   <= '0;
      rd2_hold <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept && is_multi) begin
            state    <= (alu_op == 6'd16) ? S_MUL : S_DIV;
            cnt      <= CNT_LAST;
            acc_hi   <= '0;
            acc_lo   <= rd1;
            opnd_b   <= op_b;
            rd2_hold <= rd2;
          end
        end
        S_MUL, S_DIV: begin
          acc_hi <= iter_hi;
          acc_lo <= iter_lo;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            hi    <= iter_hi;
            lo    <= iter_lo;
            state <= out_free ? S_IDLE : S_DONE;
          end
        end
        default: begin
          if (out_free) state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b1;
      rd2_out    <= '0;
      wr_out     <= '0;
    end else if (accept && !is_multi) begin
      out_valid  <= 1'b1;
      alu_result <= alu_y;
      zero       <= (alu_y == '0);
      rd2_out    <= rd2;
      wr_out     <= wr_in;
    end else if (mc_load) begin
      out_valid  <= 1'b1;
      alu_result <= '0;
      zero       <= 1'b1;
      rd2_out    <= rd2_hold;
      wr_out     <= '0;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: a 32-bit instance for most scenarios and
// a 16-bit instance for latency scaling.
module tb_exe_stage_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, alu_src, out_valid, out_ready, zero, busy;
  logic [31:0] rd1, rd2, imm, alu_result, rd2_out, hi, lo;
  logic [4:0]  shamt, wr_in, wr_out;
  logic [5:0]  alu_op;
  logic [1:0]  fsm_state;

  logic        in_valid16, in_ready16, alu_src16, out_valid16, out_ready16, zero16, busy16;
  logic [15:0] rd1_16, rd2_16, imm16, alu_result16, rd2_out16, hi16, lo16;
  logic [3:0]  shamt16;
  logic [4:0]  wr_in16, wr_out16;
  logic [5:0]  alu_op16;
  logic [1:0]  fsm_state16;

  int checks = 0;
  int errors = 0;

  exe_stage_mc u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rd1(rd1), .rd2(rd2), .imm(imm), .alu_src(alu_src), .shamt(shamt),
    .alu_op(alu_op), .wr_in(wr_in), .out_valid(out_valid), .out_ready(out_ready),
    .alu_result(alu_result), .zero(zero), .rd2_out(rd2_out), .wr_out(wr_out),
    .hi(hi), .lo(lo), .busy(busy), .fsm_state(fsm_state)
  );

  exe_stage_mc #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .rd1(rd1_16), .rd2(rd2_16), .imm(imm16), .alu_src(alu_src16), .shamt(shamt16),
    .alu_op(alu_op16), .wr_in(wr_in16), .out_valid(out_valid16), .out_ready(out_ready16),
    .alu_result(alu_result16), .zero(zero16), .rd2_out(rd2_out16), .wr_out(wr_out16),
    .hi(hi16), .lo(lo16), .busy(busy16), .fsm_state(fsm_state16)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drivers
  task automatic set_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic src, input logic [4:0] sh,
                        input logic [4:0] wr);
    in_valid = 1'b1;
    alu_op   = op;
    rd1      = a;
    rd2      = b;
    imm      = im;
    alu_src  = src;
    shamt    = sh;
    wr_in    = wr;
  endtask

  // Issues a multi-cycle op and counts edges after accept until busy drops.
  task automatic run_multi(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat);
    set_op(op, a, b, 32'h0, 1'b0, 5'd0, 5'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rd1 = 32'hDEAD_BEEF;
    rd2 = 32'h1111_2222;
    lat = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_multi16(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                             output int lat);
    in_valid16 = 1'b1;
    alu_op16   = op;
    rd1_16     = a;
    rd2_16     = b;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    rd1_16 = 16'h5A5A;
    lat = 0;
    for (int i = 0; i < 100 && busy16; i++) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    set_op(6'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0);
    in_valid = 1'b0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; alu_op16 = 6'd0; rd1_16 = '0; rd2_16 = '0;
    imm16 = '0; alu_src16 = 1'b0; shamt16 = '0; wr_in16 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
    checks++; if ({alu_result, hi, lo} !== 96'h0) begin errors++; $display("FAIL reset_regs: got %h %h %h expected 0", alu_result, hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add();
    set_op(6'd0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd3);
    @(posedge clk); #1;
    checks++; if (alu_result !== 32'd4) begin errors++; $display("FAIL add_result: got %h expected 4", alu_result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero: got %b expected 0", zero); end
    checks++; if (wr_out !== 5'd3) begin errors++; $display("FAIL add_wr: got %0d expected 3", wr_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b expected 1", out_valid); end
  endtask

  task automatic test_back_to_back();
    set_op(6'd1, 32'h1234, 32'h1234, 32'h0, 1'b0, 5'd0, 5'd5);
    @(posedge clk); #1;
    checks++; if ({alu_result, zero} !== {32'h0, 1'b1}) begin errors++; $display("FAIL sub_eq: got %h z=%b expected 0 z=1", alu_result, zero); end
    set_op(6'd6, 32'h8000_0000, 32'h1, 32'h0, 1'b0, 5'd0, 5'd6);
    @(posedge clk); #1;
    checks++; if ({alu_result, zero, wr_out} !== {32'h1, 1'b0, 5'd6}) begin errors++; $display("FAIL slt_neg: got %h z=%b wr=%0d expected 1 z=0 wr=6", alu_result, zero, wr_out); end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_clear: got %b expected 0", out_valid); end
  endtask

  task automatic test_alu_ops();
    logic [5:0]  ops [11];
    logic [31:0] av  [11];
    logic [31:0] bv  [11];
    logic [4:0]  sh  [11];
    logic [31:0] ev  [11];
    ops = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd1, 6'd13};
    av  = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234, 32'hF0F0_1234,
            32'hF0F0_1234, 32'h0, 32'h0, 32'h0, 32'd3, 32'd3};
    bv  = '{32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF, 32'h0FF0_00FF,
            32'h0FF0_00FF, 32'h8000_0010, 32'h8000_0010, 32'h8000_0010, 32'd5, 32'd5};
    sh  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0};
    ev  = '{32'h00F0_0034, 32'hFFF0_12FF, 32'hFF00_12CB, 32'h000F_ED00, 32'h1,
            32'h0, 32'h0000_0100, 32'h0800_0001, 32'hF800_0001, 32'hFFFF_FFFE, 32'h0};
    for (int i = 0; i < 11; i++) begin
      set_op(ops[i], av[i], bv[i], 32'h0, 1'b0, sh[i], 5'd1);
      @(posedge clk); #1;
      checks++;
      if ({alu_result, zero} !== {ev[i], (ev[i] == 32'h0)})
        begin errors++; $display("FAIL alu_op%0d: got %h z=%b expected %h", ops[i], alu_result, zero, ev[i]); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_op(6'd0, 32'd1, 32'd2, 32'h0, 1'b0, 5'd0, 5'd7);
    @(posedge clk); #1;
    set_op(6'd0, 32'd10, 32'd20, 32'h0, 1'b0, 5'd0, 5'd8);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({in_ready, out_valid, alu_result, wr_out} !== {1'b0, 1'b1, 32'd3, 5'd7})
        begin errors++; $display("FAIL hold_c%0d: got rdy=%b v=%b %h wr=%0d expected rdy=0 v=1 3 wr=7", i, in_ready, out_valid, alu_result, wr_out); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    checks++; if ({out_valid, alu_result, wr_out} !== {1'b1, 32'd30, 5'd8}) begin errors++; $display("FAIL release_accept: got v=%b %h wr=%0d expected v=1 1e wr=8", out_valid, alu_result, wr_out); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_multu();
    int lat;
    set_op(6'd16, 32'hFFFF_FFFF, 32'd2, 32'h0, 1'b0, 5'd0, 5'd9);
    @(posedge clk); #1;
    checks++; if ({busy, in_ready} !== 2'b10) begin errors++; $display("FAIL mul_start: got busy=%b rdy=%b expected busy=1 rdy=0", busy, in_ready); end
    in_valid = 1'b0; rd1 = 32'h0BAD_0BAD;
    lat = 0;
    for (int i = 0; i < 100 && busy; i++) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 32) begin errors++; $display("FAIL mul_latency: got %0d expected 32", lat); end
    checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL mul_hilo: got %h %h expected 1 fffffffe", hi, lo); end
    checks++; if ({out_valid, alu_result, zero, wr_out, rd2_out} !== {1'b1, 32'h0, 1'b1, 5'd0, 32'd2})
      begin errors++; $display("FAIL mul_exmem: got v=%b %h z=%b wr=%0d rd2=%h expected v=1 0 z=1 wr=0 rd2=2", out_valid, alu_result, zero, wr_out, rd2_out); end
    set_op(6'd11, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4);
    @(posedge clk); #1;
    checks++; if ({alu_result, wr_out} !== {32'd1, 5'd4}) begin errors++; $display("FAIL mfhi: got %h wr=%0d expected 1 wr=4", alu_result, wr_out); end
    set_op(6'd12, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd4);
    @(posedge clk); #1;
    checks++; if (alu_result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mflo: got %h expected fffffffe", alu_result); end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu();
    int lat;
    run_multi(6'd17, 32'd100, 32'd7, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div_latency: got %0d expected 32", lat); end
    checks++; if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL div_100_7: got hi=%h lo=%h expected hi=2 lo=e", hi, lo); end
    run_multi(6'd17, 32'd9, 32'd0, lat);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div0_latency: got %0d expected 32", lat); end
    checks++; if ({hi, lo} !== {32'd9, 32'hFFFF_FFFF}) begin errors++; $display("FAIL div_by_zero: got hi=%h lo=%h expected hi=9 lo=ffffffff", hi, lo); end
    run_multi(6'd17, 32'hFFFF_FFFF, 32'h0001_0000, lat);
    checks++; if ({hi, lo} !== {32'h0000_FFFF, 32'h0000_FFFF}) begin errors++; $display("FAIL div_large: got hi=%h lo=%h expected hi=ffff lo=ffff", hi, lo); end
    run_multi(6'd17, 32'd9, 32'd0, lat);
  endtask

  task automatic test_reset_mid();
    set_op(6'd16, 32'd7, 32'd9, 32'h0, 1'b0, 5'd0, 5'd2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid, busy, hi, lo} !== {2'b00, 64'h0}) begin errors++; $display("FAIL mid_reset: got v=%b busy=%b hi=%h lo=%h expected all 0", out_valid, busy, hi, lo); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", in_ready); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if ({out_valid, hi, lo} !== {1'b0, 64'h0}) begin errors++; $display("FAIL mid_reset_no_result: got v=%b hi=%h lo=%h expected 0", out_valid, hi, lo); end
  endtask

  task automatic test_width16();
    int lat;
    run_multi16(6'd16, 16'hFFFF, 16'h0003, lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL w16_mul_latency: got %0d expected 16", lat); end
    checks++; if ({hi16, lo16} !== 32'h0002_FFFD) begin errors++; $display("FAIL w16_mul: got hi=%h lo=%h expected 0002 fffd", hi16, lo16); end
    checks++; if ({out_valid16, rd2_out16} !== {1'b1, 16'h0003}) begin errors++; $display("FAIL w16_exmem: got v=%b rd2=%h expected v=1 0003", out_valid16, rd2_out16); end
    run_multi16(6'd17, 16'h1234, 16'h0010, lat);
    checks++; if ({hi16, lo16} !== 32'h0004_0123) begin errors++; $display("FAIL w16_div: got hi=%h lo=%h expected 0004 0123", hi16, lo16); end
    in_valid16 = 1'b1; alu_op16 = 6'd16; rd1_16 = 16'h00FF; rd2_16 = 16'h0101;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({out_valid16, busy16, hi16, lo16} !== 34'h0) begin errors++; $display("FAIL w16_mid_reset: got v=%b busy=%b hi=%h lo=%h expected all 0", out_valid16, busy16, hi16, lo16); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready16 !== 1'b1) begin errors++; $display("FAIL w16_ready: got %b expected 1", in_ready16); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu_ops();
    test_backpressure();
    test_multu();
    test_divu();
    test_reset_mid();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised execute stage for the MIPS pipeline, sitting between decode and memory access. It is the successor to the single-cycle EXE block. It adds an internal EX/MEM output register with a valid/ready handshake, and an iterative unsigned multiply/divide unit that writes HI/LO. While a multi-cycle operation runs, the stage stalls decode.

## Interface
Parameters:
- WIDTH, 32, datapath width. Must be a power of two, at least 8.
- REG_ADDR_W, 5, register-file address width.
- SHAMT_W, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle. Transfer happens when in_valid && in_ready.
- rd1  in  WIDTH  operand A.
- rd2  in  WIDTH  register operand B; also forwarded for stores.
- imm  in  WIDTH  sign-extended immediate.
- alu_src  in  1  when 1, operand B = imm; when 0, operand B = rd2.
- shamt  in  SHAMT_W  shift amount.
- alu_op  in  6  operation code (see Operation).
- wr_in  in  REG_ADDR_W  destination register.
- out_valid  out  1  EX/MEM register holds a result.
- out_ready  in  1  memory stage consumes this cycle.
- alu_result  out  WIDTH  registered result.
- zero  out  1  registered (alu_result == 0).
- rd2_out  out  WIDTH  registered copy of rd2.
- wr_out  out  REG_ADDR_W  registered destination.
- hi, lo  out  WIDTH  HI/LO architectural registers.
- busy  out  1  multiply/divide in progress.

## Operation
Single-cycle alu_op codes. A = rd1, B = selected operand.
- 0: ADD, A+B, modulo 2^WIDTH.
- 1: SUB, A-B, modulo 2^WIDTH.
- 2: AND. 3: OR. 4: XOR. 5: NOR.
- 6: SLT (signed), result 1 or 0.
- 7: SLTU (unsigned), result 1 or 0.
- 8: SLL, B<<shamt.
- 9: SRL, B>>shamt.
- 10: SRA, B>>>shamt.
- 11: MFHI, result = hi.
- 12: MFLO, result = lo.
- Any other code except 16 and 17: result 0.

Multi-cycle codes:
- 16: MULTU. {hi,lo} = A×B, unsigned, 2·WIDTH-bit product; shift-add, one bit per cycle.
- 17: DIVU. lo = A/B, hi = A%B; restoring division, one bit per cycle.
- Divide by zero: no special path. Gives lo = all ones, hi = A, with the same latency.
- On completion, the EX/MEM register is loaded with alu_result = 0, zero = 1, wr_out = 0, rd2_out = rd2 captured at accept.

Other rules:
- Operands are captured at accept. Input changes during busy are ignored.
- in_ready = (state == IDLE) && (!out_valid || out_ready).
- Single-cycle accept loads the EX/MEM register (alu_result, zero, rd2_out, wr_out) and sets out_valid.
- out_valid clears on out_ready when no new load occurs in that cycle.
- While out_valid && !out_ready, all registered outputs hold stable.

FSM:
- IDLE → MUL or DIV on accept of code 16 or 17.
- MUL/DIV: an iteration counter runs from WIDTH-1 down to 0. When it reaches 0, HI/LO are written in that same edge.
  - If the EX/MEM register is free (!out_valid || out_ready), it is loaded and the FSM goes to IDLE.
  - Otherwise the FSM goes to DONE.
- DONE: loads the EX/MEM register and goes to IDLE on the first edge where !out_valid || out_ready.
- busy = (state != IDLE).

## Timing
- Reset values, applied asynchronously:
  - state = IDLE.
  - out_valid, alu_result, rd2_out, wr_out, hi, lo, busy = 0.
  - zero = 1.
  - in_ready = 1 once rst_n is high.
- Single-cycle op accepted at edge N: out_valid = 1 with the result after edge N. Throughput is one per cycle with no backpressure.
- MULTU/DIVU accepted at edge N:
  - busy = 1 and in_ready = 0 after edge N.
  - HI/LO update, out_valid rises, and busy falls after edge N+WIDTH, unless output backpressure holds the FSM in DONE.
- MFHI/MFLO accepted right after completion sees the new HI/LO.
- Reset asserted mid-operation aborts it: HI/LO = 0 and no result is produced.
- An accept and an output drain in the same cycle are legal. The new result replaces the old one and out_valid stays 1.

## Test plan
- Reset, then ADD with rd1 = 5, imm = 0xFFFFFFFF, alu_src = 1, wr_in = 3 → one cycle later alu_result = 4, zero = 0, wr_out = 3, out_valid = 1.
- SUB with rd1 = rd2 = 0x1234, then SLT with rd1 = 0x80000000, rd2 = 1 → results 0 (zero = 1), then 1, on consecutive cycles.
- Hold out_ready = 0 with out_valid = 1 → in_ready = 0 and outputs stable for 5 cycles. Release → the pending input is accepted that same cycle.
- MULTU 0xFFFFFFFF × 2, then MFHI → busy for 32 cycles; hi = 1, lo = 0xFFFFFFFE; MFHI returns 1.
- DIVU 100 / 7, then DIVU 9 / 0 → hi = 2, lo = 14; then hi = 9, lo = 0xFFFFFFFF, each after 32 cycles.
- Assert rst_n = 0 at iteration 10 of a MULTU → out_valid = 0, hi = lo = 0, in_ready = 1 after release. Repeat with WIDTH = 16 → latency is 16 cycles.
